fipo_cfg_loader: RTL and testbench

Parametrised serial-to-parallel configuration loader, successor to the fixed 312-bit FIPO store.
- Accepts LANES bits per beat over a valid/ready handshake into a shadow register.
- Commits the complete frame atomically to an active register, so downstream logic (RSNN weights/params) never sees a partial frame.
- Adds start/abort, flow control, and sticky overflow reporting.

---
 rtl/fipo_pkg.sv | 19 +
 rtl/fipo_cfg_loader.sv | 99 +++++++++
 tb/tb_fipo_cfg_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fipo_pkg.sv
// Definitions shared by the configuration loader and the RSNN core: FSM states,
// the default frame geometry and the beat-to-bit-offset mapping.
package fipo_pkg;

    localparam int FIPO_DATA_W = 312;
    localparam int FIPO_LANES  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } fipo_state_t;

    // Beat k occupies bits [k*lanes +: lanes] of the frame.
    function automatic int unsigned beat_offset(input int unsigned beat, input int unsigned lanes);
        return beat * lanes;
    endfunction

endpackage

// File: rtl/fipo_cfg_loader.sv
// Serial-to-parallel configuration loader: beats fill a shadow frame that is copied
// to active_out in one cycle, so consumers never observe a partially loaded frame.
module fipo_cfg_loader
    import fipo_pkg::*;
#(
    parameter int DATA_W = FIPO_DATA_W,
    parameter int LANES  = FIPO_LANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              start,
    input  logic              in_valid,
    input  logic [LANES-1:0]  in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] active_out,
    output logic              busy,
    output logic              beat_written,
    output logic              frame_done,
    output logic              overflow,
    input  logic              clear_ovf
);

    localparam int BEATS = DATA_W / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int OFF_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    fipo_state_t       state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] shadow;
    logic [OFF_W-1:0]  offset;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] lane_data;
    logic              accept;

    assign in_ready = (state == LOAD) && enable;
    assign busy     = (state != IDLE);
    // A start in LOAD aborts the frame, so a beat offered alongside it is dropped.
    assign accept   = in_ready && in_valid && !start;

    assign offset    = OFF_W'(beat_offset(32'(count), LANES));
    assign lane_mask = DATA_W'({LANES{1'b1}}) << offset;
    assign lane_data = DATA_W'(in_data) << offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            shadow       <= '0;
            active_out   <= '0;
            beat_written <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            beat_written <= accept;
            frame_done   <= 1'b0;

            if (in_valid && enable && (state != LOAD)) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end

            if (enable) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state  <= LOAD;
                            count  <= '0;
                            shadow <= '0;
                        end
                    end
                    LOAD: begin
                        if (start) begin
                            count  <= '0;
                            shadow <= '0;
                        end else if (in_valid) begin
                            shadow <= (shadow & ~lane_mask) | lane_data;
                            if (count == LAST) begin
                                count <= '0;
                                state <= COMMIT;
                            end else begin
                                count <= count + CNT_W'(1);
                            end
                        end
                    end
                    COMMIT: begin
                        active_out <= shadow;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fipo_cfg_loader.sv
// Directed bench for fipo_cfg_loader: a 312x1 instance and a 16x4 instance, with
// expected frames queued by the stimulus and checked by monitors on frame_done.
module tb_fipo_cfg_loader;

    localparam int W  = 312;
    localparam int W4 = 16;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         enable, start, in_valid, clear_ovf;
    logic [0:0]   in_data;
    logic         in_ready, busy, beat_written, frame_done, overflow;
    logic [W-1:0] active_out;

    logic          enable4, start4, in_valid4, clear_ovf4;
    logic [3:0]    in_data4;
    logic          in_ready4, busy4, beat_written4, frame_done4, overflow4;
    logic [W4-1:0] active_out4;

    int n_vec  = 0;
    int n_err  = 0;
    int bw_cnt = 0;
    int bw0;

    logic [W-1:0]  exp_q[$];
    logic [W4-1:0] exp4_q[$];
    logic [W-1:0]  v_alt, v_ones, v_fc, v_post;

    fipo_cfg_loader #(.DATA_W(W), .LANES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .active_out(active_out), .busy(busy), .beat_written(beat_written),
        .frame_done(frame_done), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    fipo_cfg_loader #(.DATA_W(W4), .LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable4), .start(start4),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .active_out(active_out4), .busy(busy4), .beat_written(beat_written4),
        .frame_done(frame_done4), .overflow(overflow4), .clear_ovf(clear_ovf4)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitors: pop the expected frame whenever a commit is reported.
    initial forever begin
        @(negedge clk);
        if (beat_written === 1'b1) bw_cnt++;
        if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_done", 1, 0);
            end else begin
                check("frame_value", active_out, exp_q.pop_front());
                check("busy_falls_with_done", W'(busy), 0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (frame_done4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                check("unexpected_frame_done4", 1, 0);
            end else begin
                check("frame_value4", W'(active_out4), W'(exp4_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_beat(input logic d, input bit rnd);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rnd && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                continue;
            end
            in_valid   = 1'b1;
            in_data[0] = d;
            #1;
            if (in_ready) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("beat_stalled", 1, 0);
    endtask

    task automatic send_frame(input logic [W-1:0] v, input bit rnd, input int nbeats);
        for (int i = 0; i < nbeats; i++) send_beat(v[i], rnd);
    endtask

    // Last beat was accepted at the previous edge: one COMMIT cycle, then frame_done.
    task automatic finish_frame(input string tag);
        @(negedge clk);
        check({tag, "_commit_no_done"}, W'(frame_done), 0);
        check({tag, "_commit_busy"}, W'(busy), 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, W'(frame_done), 1);
    endtask

    task automatic send_beat4(input logic [3:0] d);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            in_valid4 = 1'b1;
            in_data4  = d;
            #1;
            if (in_ready4) begin
                @(posedge clk);
                #1 in_valid4 = 1'b0;
                return;
            end
        end
        in_valid4 = 1'b0;
        check("beat4_stalled", 1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; clear_ovf = 1'b0;
        enable4 = 1'b0; start4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; clear_ovf4 = 1'b0;
        for (int i = 0; i < W; i++) begin
            v_alt[i]  = (i % 2 == 0);
            v_ones[i] = 1'b1;
            v_fc[i]   = (((i * 37 + 11) % 7) < 3);
            v_post[i] = ((i % 4) >= 2);
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_active_out", active_out, 0);
        check("rst_busy", W'(busy), 0);
        check("rst_beat_written", W'(beat_written), 0);
        check("rst_frame_done", W'(frame_done), 0);
        check("rst_overflow", W'(overflow), 0);
        check("rst_in_ready", W'(in_ready), 0);
        rst_n = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("idle_in_ready", W'(in_ready), 0);

        // Overflow: set in IDLE, set beats clear, then clear alone
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("ovf_set", W'(overflow), 1);
        in_valid = 1'b1; clear_ovf = 1'b1;
        @(posedge clk);
        #1 begin in_valid = 1'b0; clear_ovf = 1'b0; end
        @(negedge clk);
        check("ovf_set_wins", W'(overflow), 1);
        clear_ovf = 1'b1;
        @(posedge clk);
        #1 clear_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", W'(overflow), 0);

        // start is ignored while disabled
        enable = 1'b0;
        start_frame();
        @(negedge clk);
        check("start_gated", W'(busy), 0);
        enable = 1'b1;

        // 16x4 instance: nibbles A,5,F,0 -> 0F5A, done two edges after last accept
        enable4 = 1'b1;
        exp4_q.push_back(16'h0F5A);
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        send_beat4(4'hA);
        send_beat4(4'h5);
        send_beat4(4'hF);
        send_beat4(4'h0);
        @(negedge clk);
        check("lanes4_commit_no_done", W'(frame_done4), 0);
        @(negedge clk);
        check("lanes4_done_pulse", W'(frame_done4), 1);
        check("lanes4_active", W'(active_out4), W'(16'h0F5A));

        // Full 312-beat frame of alternating bits
        exp_q.push_back(v_alt);
        bw0 = bw_cnt;
        start_frame();
        send_frame(v_alt, 1'b0, W);
        finish_frame("alt");
        check("alt_beat_count", W'(bw_cnt - bw0), W'(312));
        check("alt_no_overflow", W'(overflow), 0);

        // Abort after 100 ones, with a beat offered alongside the restart
        bw0 = bw_cnt;
        start_frame();
        send_frame(v_ones, 1'b0, 100);
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; in_data = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; in_valid = 1'b0; end
        @(negedge clk);
        check("abort_no_beat_pulse", W'(beat_written), 0);
        check("abort_keeps_active", active_out, v_alt);
        check("abort_still_busy", W'(busy), 1);
        send_frame('0, 1'b0, W);
        check("abort_pre_commit_active", active_out, v_alt);
        exp_q.push_back('0);
        finish_frame("abort");
        check("abort_beat_count", W'(bw_cnt - bw0), W'(412));

        // Flow control: random valid gaps plus a 5-cycle enable drop
        exp_q.push_back(v_fc);
        bw0 = bw_cnt;
        start_frame();
        fork
            send_frame(v_fc, 1'b1, W);
            begin
                repeat (150) @(posedge clk);
                @(negedge clk);
                enable = 1'b0;
                repeat (5) begin
                    #2 check("fc_ready_low", W'(in_ready), 0);
                    @(negedge clk);
                end
                enable = 1'b1;
            end
        join
        finish_frame("fc");
        check("fc_beat_count", W'(bw_cnt - bw0), W'(312));

        // Committed all-ones frame, then reset in the middle of the next one
        exp_q.push_back(v_ones);
        start_frame();
        send_frame(v_ones, 1'b0, W);
        finish_frame("ones");
        start_frame();
        send_frame(v_ones, 1'b0, 200);
        rst_n = 1'b0;
        #1;
        check("midrst_active_cleared", active_out, 0);
        check("midrst_busy", W'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", W'(frame_done), 0);
        end
        check("midrst_idle_ready", W'(in_ready), 0);

        exp_q.push_back(v_post);
        start_frame();
        send_frame(v_post, 1'b0, W);
        finish_frame("post");

        repeat (4) @(negedge clk);
        check("scoreboard_drained", W'(exp_q.size()), 0);
        check("scoreboard4_drained", W'(exp4_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
